// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid-register stage.
// The state encoding is the concatenation {skid_v, main_v}.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StBusy  = ST_BUSY,
    StFull  = ST_FULL
  } state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and an optional synchronous zeroing clear.
// When CLEAR_DATA is 0, the clear and reset inputs leave the contents untouched.
module pipe_data_reg #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (CLEAR_DATA && (rst || clear)) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
// in_ready is a flop output, so back-pressure never forms a combinational path upstream.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;
  logic main_en, main_from_skid, skid_en;
  logic accept, deliver;
  logic [WIDTH-1:0] main_data, skid_data, main_next;
  state_e state;

  assign state   = state_e'({skid_v_q, main_v_q});
  assign accept  = in_valid && !skid_v_q;
  assign deliver = main_v_q && out_ready;

  always_comb begin
    main_v_d       = main_v_q;
    skid_v_d       = skid_v_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (rst || flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      unique case (state)
        StEmpty: begin
          if (accept) begin
            main_en  = 1'b1;
            main_v_d = 1'b1;
          end
        end
        StBusy: begin
          if (accept && deliver) begin
            main_en = 1'b1;
          end else if (accept) begin
            skid_en  = 1'b1;
            skid_v_d = 1'b1;
          end else if (deliver) begin
            main_v_d = 1'b0;
          end
        end
        StFull: begin
          // in_ready is low here, so only the skid beat can refill main.
          if (deliver) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            skid_v_d       = 1'b0;
          end
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    main_v_q <= main_v_d;
    skid_v_q <= skid_v_d;
  end

  assign main_next = main_from_skid ? skid_data : in_data;

  pipe_data_reg #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main_reg (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .en    (main_en),
    .d     (main_next),
    .q     (main_data)
  );

  pipe_data_reg #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid_reg (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_data)
  );

  assign out_valid = main_v_q;
  assign out_data  = main_data;
  assign in_ready  = !skid_v_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, then a random soak against a queue model.
module tb_pipe_skid_reg;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH      (W),
    .CLEAR_DATA (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  int checks = 0;
  int errors = 0;

  // Reference: ordered list of held beats plus the value last shown on out_data.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_data = '0;
  int           delivered = 0;

  typedef struct {
    bit           r, f, iv;
    logic [W-1:0] id;
    bit           ordy;
    bit           ov, ir;
    int           occ;
    logic [W-1:0] od;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit m_valid, m_ready, dlv, acc;
    m_valid = mq.size() > 0;
    m_ready = mq.size() < 2;
    dlv     = m_valid && out_ready && !rst;
    acc     = in_valid && m_ready;
    if (dlv) begin
      void'(mq.pop_front());
      delivered++;
    end
    if (rst || flush) begin
      mq.delete();
      m_data = '0;
    end else begin
      if (acc) mq.push_back(in_data);
      if (mq.size() > 0) m_data = mq[0];
    end
  endtask

  // Called at a falling edge: drive, step the model, wait to the next falling edge.
  task automatic cycle(input bit r, input bit f, input bit iv, input logic [W-1:0] id,
                       input bit ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " no_x"}, W'($isunknown({out_valid, in_ready, occupancy, out_data})), '0);
    chk({tag, " out_valid"}, W'(out_valid), W'(mq.size() > 0));
    chk({tag, " in_ready"}, W'(in_ready), W'(mq.size() < 2));
    chk({tag, " occupancy"}, W'(occupancy), W'(mq.size()));
    chk({tag, " occ_le2"}, W'(occupancy <= 2'd2), W'(1));
    chk({tag, " out_data"}, out_data, m_data);
  endtask

  task automatic add(input bit r, f, iv, input logic [W-1:0] id, input bit ordy,
                     input bit ov, ir, input int occ, input logic [W-1:0] od);
    vecs.push_back('{r: r, f: f, iv: iv, id: id, ordy: ordy, ov: ov, ir: ir, occ: occ, od: od});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset and idle.
    add(1, 0, 0, 32'h0, 0,  0, 1, 0, 32'h0);
    add(1, 0, 0, 32'h0, 0,  0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h5, 0,  0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h6, 1,  0, 1, 0, 32'h0);
    // Streaming 1..8 with no bubbles.
    for (int k = 1; k <= 8; k++) add(0, 0, 1, W'(k), 1,  1, 1, 1, W'(k));
    add(0, 0, 0, 32'h0, 1,  0, 1, 0, 32'h8);
    // Back-pressure: B into skid, C held upstream, then drain in order.
    add(0, 0, 1, 32'hA, 1,  1, 1, 1, 32'hA);
    add(0, 0, 1, 32'hB, 0,  1, 0, 2, 32'hA);
    add(0, 0, 1, 32'hC, 0,  1, 0, 2, 32'hA);
    add(0, 0, 1, 32'hC, 1,  1, 1, 1, 32'hB);
    add(0, 0, 1, 32'hC, 1,  1, 1, 1, 32'hC);
    add(0, 0, 0, 32'h0, 1,  0, 1, 0, 32'hC);
    // Flush while full with a beat presented; that beat must vanish.
    add(0, 0, 1, 32'h1, 1,  1, 1, 1, 32'h1);
    add(0, 0, 1, 32'h2, 0,  1, 0, 2, 32'h1);
    add(0, 1, 1, 32'hFF, 0, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'hFF, 0, 0, 1, 0, 32'h0);
    // Flush coincident with a deliver.
    add(0, 0, 1, 32'h5, 1,  1, 1, 1, 32'h5);
    add(0, 1, 0, 32'h0, 1,  0, 1, 0, 32'h0);
    // Simultaneous rst and flush.
    add(0, 0, 1, 32'h7, 0,  1, 1, 1, 32'h7);
    add(1, 1, 1, 32'h9, 0,  0, 1, 0, 32'h0);
    // Reset while full, ignoring out_ready.
    add(0, 0, 1, 32'h3, 0,  1, 1, 1, 32'h3);
    add(0, 0, 1, 32'h4, 0,  1, 0, 2, 32'h3);
    add(1, 0, 1, 32'h8, 1,  0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0, 1,  0, 1, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("vec%0d out_valid", i), W'(out_valid), W'(vecs[i].ov));
      chk($sformatf("vec%0d in_ready", i), W'(in_ready), W'(vecs[i].ir));
      chk($sformatf("vec%0d occupancy", i), W'(occupancy), W'(vecs[i].occ));
      chk($sformatf("vec%0d out_data", i), out_data, vecs[i].od);
    end

    // Random soak against the queue model.
    cycle(1, 0, 0, '0, 0);
    chk_model("soak_start");
    for (int n = 0; n < 10000; n++) begin
      cycle($urandom_range(499) == 0, $urandom_range(15) == 0, $urandom_range(9) < 7,
            W'($urandom), $urandom_range(9) < 6);
      chk_model($sformatf("soak%0d", n));
    end
    chk("soak_delivered_nonzero", W'(delivered > 1000), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer. It replaces plain enable/clear flops between CPU pipeline stages (IF/ID/EX/MEM/WB) and on AXI-facing request paths. Back-pressure is absorbed without a combinational ready path from downstream to upstream. It supports a synchronous flush for branch/exception squash and keeps full 1-beat-per-cycle throughput.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- CLEAR_DATA, 1, 1: data registers zeroed on rst/flush; 0: data registers keep stale contents, only valid bits cleared

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous squash of all held beats; priority over handshakes
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept; registered, depends only on internal state
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  payload, driven directly from main register
- occupancy  out  2  beats held: 0, 1 or 2

## Operation
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d).
- States, encoded by {skid_v, main_v}:
  - EMPTY (0 beats)
  - BUSY (1 beat, in main)
  - FULL (2 beats)
- Output mapping: out_valid = main_v, out_data = main_d, in_ready = !skid_v, occupancy = main_v + skid_v.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- Transitions, evaluated only when rst=0 and flush=0:
  - EMPTY: accept → main ← in_data, BUSY; else stay in EMPTY.
  - BUSY, accept & deliver → main ← in_data, stay in BUSY.
  - BUSY, accept & !deliver → skid ← in_data, FULL.
  - BUSY, !accept & deliver → EMPTY.
  - BUSY, neither → hold.
  - FULL, deliver → main ← skid_d, skid_v ← 0, BUSY. in_ready=0, so input is ignored.
  - FULL, !deliver → hold.
- Ordering: beats leave in arrival order. No beat is duplicated or lost except by flush/rst.
- Flush: main_v, skid_v ← 0 next cycle. Any beat presented with in_valid in the flush cycle is discarded, even though in_ready may be 1. Upstream treats flush as covering its current beat. A deliver in the flush cycle still completes, since out_valid was already visible.
- rst behaves like flush, and additionally ignores out_ready.
- CLEAR_DATA=1: main_d, skid_d ← 0 on rst/flush.

## Timing
- Reset values: out_valid=0, in_ready=1, occupancy=0, out_data=0 (for CLEAR_DATA=1; undefined/stale for CLEAR_DATA=0 until first load).
- Latency: a beat accepted at edge N is on out_data/out_valid after edge N (visible in cycle N+1). Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- in_ready falls one cycle after out_ready first drops while a beat arrives. The skid entry captures the beat in flight.
- Recovery: in_ready rises in the cycle after the FULL→BUSY deliver.
- Combinational paths: none from out_ready to in_ready, and none from in_* to out_*.
- Simultaneous rst and flush: identical result.
- rst mid-transfer: all beats dropped with no partial state.

## Structure
- Shared package pipe_pkg: state localparams ST_EMPTY=2'b00, ST_BUSY=2'b01, ST_FULL=2'b11, and the occupancy width constant.
- Sub-module pipe_data_reg (WIDTH, CLEAR_DATA): WIDTH-bit register with rst, en and clear. It is instantiated twice, once for main and once for skid. The top level holds only the valid bits and the next-state logic.

## Test plan
- Reset then idle: rst=1 for 2 cycles → out_valid=0, in_ready=1, occupancy=0, out_data=0. No output change with in_valid=0.
- Streaming: out_ready=1, in_data=1..8 on consecutive cycles → out_data=1..8 one cycle later, no bubbles, occupancy stays at 1.
- Back-pressure: stream 0xA,0xB,0xC and drop out_ready when 0xA is at the output.
  - 0xB is captured in skid; occupancy=2; in_ready=0 next cycle; 0xC is held upstream.
  - On release, output is 0xA,0xB,0xC in order with no loss.
- Flush while FULL: occupancy=2, assert flush with in_valid=1, in_data=0xFF.
  - Next cycle: occupancy=0, out_valid=0, in_ready=1, out_data=0; 0xFF never appears.
- Flush during deliver: out_valid=1, out_ready=1 and flush in the same cycle → the beat counts as delivered; stage is empty afterwards.
- Random soak: random in_valid/out_ready/flush over 10k cycles against a scoreboard queue. Checks:
  - order preserved
  - occupancy ≤2 at all times
  - in_ready == (occupancy<2 when skid is empty)
  - no X on any output after reset
